alu_issue: RTL

Operand-preparation and issue stage sitting directly upstream of the combinational `alu`. It accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO. It drives registered operands and a function select into the ALU, pre-negating `in_b` for subtract and signed-compare, because the ALU adds `in_a + in_b` for those ops. It then captures `res`/`cout`/`Overflow` into a response register held under a valid/ready handshake, and keeps a saturating overflow event counter.

---
 rtl/alu_issue.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Command FIFO, operand preparation and response capture stage
//            placed in front of a combinational ALU. Subtract and signed
//            compare have in_b two's-complement negated so the ALU can
//            always add. Also keeps a saturating overflow event counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [2:0]   alu_fun_sel,
  output logic [W-1:0] alu_in_a,
  output logic [W-1:0] alu_in_b,
  input  logic [W-1:0] alu_res,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_cout,
  output logic         rsp_overflow,
  output logic [2:0]   rsp_op,
  output logic         busy,
  output logic [15:0]  ovf_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);
  localparam logic [2:0]  C_OP_SUB = 3'd1;
  localparam logic [2:0]  C_OP_SLT = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;

  // FIFO storage and bookkeeping
  logic [2:0]     op_mem_q [DEPTH];
  logic [W-1:0]   a_mem_q  [DEPTH];
  logic [W-1:0]   b_mem_q  [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;

  // Registered outputs
  logic [2:0]     alu_fun_sel_q;
  logic [W-1:0]   alu_in_a_q;
  logic [W-1:0]   alu_in_b_q;
  logic           rsp_valid_q;
  logic [W-1:0]   rsp_res_q;
  logic           rsp_cout_q;
  logic           rsp_overflow_q;
  logic [2:0]     rsp_op_q;
  logic [15:0]    ovf_count_q;

  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic [2:0]     head_op;
  logic [W-1:0]   head_a;
  logic [W-1:0]   head_b;
  logic [W-1:0]   head_b_prep;

  // Ready depends only on the registered occupancy, never on the pop side
  assign cmd_ready  = (count_q != C_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));

  assign head_op     = op_mem_q[rd_ptr_q];
  assign head_a      = a_mem_q[rd_ptr_q];
  assign head_b      = b_mem_q[rd_ptr_q];
  // The ALU only adds for sub/slt, so present -b; the most negative value maps to itself
  assign head_b_prep = ((head_op == C_OP_SUB) || (head_op == C_OP_SLT))
                     ? (~head_b + {{(W-1){1'b0}}, 1'b1})
                     : head_b;

  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign alu_fun_sel  = alu_fun_sel_q;
  assign alu_in_a     = alu_in_a_q;
  assign alu_in_b     = alu_in_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_res      = rsp_res_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_op       = rsp_op_q;
  assign ovf_count    = ovf_count_q;

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q] <= cmd_op;
      a_mem_q[wr_ptr_q]  <= cmd_a;
      b_mem_q[wr_ptr_q]  <= cmd_b;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Issue/capture FSM with all ALU-side and response-side outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_fun_sel_q  <= '0;
      alu_in_a_q     <= '0;
      alu_in_b_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_res_q      <= '0;
      rsp_cout_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_op_q       <= '0;
      ovf_count_q    <= '0;
    end else begin
      if (pop) begin
        alu_fun_sel_q <= head_op;
        alu_in_a_q    <= head_a;
        alu_in_b_q    <= head_b_prep;
      end
      case (state_q)
        IDLE: begin
          if (pop) state_q <= EXEC;
        end
        EXEC: begin
          // ALU has had a full cycle to settle on the registered operands
          rsp_res_q      <= alu_res;
          rsp_cout_q     <= alu_cout;
          rsp_overflow_q <= alu_overflow;
          rsp_op_q       <= alu_fun_sel_q;
          rsp_valid_q    <= 1'b1;
          if (alu_overflow && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_q <= ovf_count_q + 16'd1;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
